// File: rtl/fetch_stage.sv
// fetch_stage: Y86-64 fetch stage (PC select, split/align, predict, F/D register).
// Optional FETCH_PERF_CNT_EN adds F_icount, a count of instructions loaded into D.
`default_nettype none

module fetch_stage #(
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        F_stall,
  input  logic        D_stall,
  input  logic        D_bubble,
  input  logic [3:0]  M_icode,
  input  logic        M_Cnd,
  input  logic [63:0] M_valA,
  input  logic [3:0]  W_icode,
  input  logic [63:0] W_valM,
  input  logic [7:0]  ib0,
  input  logic [7:0]  ib1,
  input  logic [7:0]  ib2,
  input  logic [7:0]  ib3,
  input  logic [7:0]  ib4,
  input  logic [7:0]  ib5,
  input  logic [7:0]  ib6,
  input  logic [7:0]  ib7,
  input  logic [7:0]  ib8,
  input  logic [7:0]  ib9,
  input  logic        imem_error,
  output logic [63:0] f_pc,
  output logic [2:0]  D_stat,
  output logic [3:0]  D_icode,
  output logic [3:0]  D_ifun,
  output logic [3:0]  D_rA,
  output logic [3:0]  D_rB,
  output logic [63:0] D_valC,
  output logic [63:0] D_valP
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [63:0] F_icount
`endif
);

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] R_NONE   = 4'hF;

  logic [63:0] F_predPC_q;
  logic [2:0]  D_stat_q;
  logic [3:0]  D_icode_q, D_ifun_q, D_rA_q, D_rB_q;
  logic [63:0] D_valC_q, D_valP_q;

  logic [3:0]  icode, ifun, rA, rB;
  logic        instr_valid, need_regids, need_valC;
  logic [63:0] valC, valP, predPC_d;
  logic [2:0]  stat;

  // Mispredicted jXX takes precedence over a returning ret.
  always_comb begin
    f_pc = F_predPC_q;
    if (M_icode == I_JXX && !M_Cnd)
      f_pc = M_valA;
    else if (W_icode == I_RET)
      f_pc = W_valM;
  end

  always_comb begin
    icode       = imem_error ? I_NOP : ib0[7:4];
    ifun        = imem_error ? 4'h0  : ib0[3:0];
    instr_valid = (icode <= 4'hB);
    need_regids = (icode == 4'h2) || (icode == 4'h3) || (icode == 4'h4) ||
                  (icode == 4'h5) || (icode == 4'h6) || (icode == 4'hA) ||
                  (icode == 4'hB);
    need_valC   = (icode == 4'h3) || (icode == 4'h4) || (icode == 4'h5) ||
                  (icode == I_JXX) || (icode == I_CALL);
    rA = R_NONE;
    rB = R_NONE;
    if (need_regids) begin
      rA = ib1[7:4];
      rB = ib1[3:0];
    end
    valC = 64'd0;
    if (need_valC)
      valC = need_regids ? {ib9, ib8, ib7, ib6, ib5, ib4, ib3, ib2}
                         : {ib8, ib7, ib6, ib5, ib4, ib3, ib2, ib1};
    valP = f_pc + 64'd1 + {63'd0, need_regids} + (need_valC ? 64'd8 : 64'd0);
    predPC_d = (icode == I_JXX || icode == I_CALL) ? valC : valP;
    if (imem_error)
      stat = STAT_ADR;
    else if (!instr_valid)
      stat = STAT_INS;
    else if (icode == I_HALT)
      stat = STAT_HLT;
    else
      stat = STAT_AOK;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      F_predPC_q <= RESET_PC;
    else if (!F_stall)
      F_predPC_q <= predPC_d;
  end

  // Stall outranks bubble; reset value equals the bubble (a nop).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      D_stat_q  <= STAT_AOK;
      D_icode_q <= I_NOP;
      D_ifun_q  <= 4'h0;
      D_rA_q    <= R_NONE;
      D_rB_q    <= R_NONE;
      D_valC_q  <= 64'd0;
      D_valP_q  <= 64'd0;
    end else if (!D_stall) begin
      if (D_bubble) begin
        D_stat_q  <= STAT_AOK;
        D_icode_q <= I_NOP;
        D_ifun_q  <= 4'h0;
        D_rA_q    <= R_NONE;
        D_rB_q    <= R_NONE;
        D_valC_q  <= 64'd0;
        D_valP_q  <= 64'd0;
      end else begin
        D_stat_q  <= stat;
        D_icode_q <= icode;
        D_ifun_q  <= ifun;
        D_rA_q    <= rA;
        D_rB_q    <= rB;
        D_valC_q  <= valC;
        D_valP_q  <= valP;
      end
    end
  end

  assign D_stat  = D_stat_q;
  assign D_icode = D_icode_q;
  assign D_ifun  = D_ifun_q;
  assign D_rA    = D_rA_q;
  assign D_rB    = D_rB_q;
  assign D_valC  = D_valC_q;
  assign D_valP  = D_valP_q;

`ifdef FETCH_PERF_CNT_EN
  logic [63:0] icount_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      icount_q <= 64'd0;
    else if (!D_stall && !D_bubble)
      icount_q <= icount_q + 64'd1;
  end

  assign F_icount = icount_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: table-driven check of fetch_stage plus stall/bubble/reset sequences.
`default_nettype none

module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        F_stall = 1'b0, D_stall = 1'b0, D_bubble = 1'b0;
  logic [3:0]  M_icode = 4'h0, W_icode = 4'h0;
  logic        M_Cnd = 1'b0;
  logic [63:0] M_valA = 64'd0, W_valM = 64'd0;
  logic [79:0] ib = 80'd0;
  logic        imem_error = 1'b0;
  logic [63:0] f_pc;
  logic [2:0]  D_stat;
  logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
  logic [63:0] D_valC, D_valP;
`ifdef FETCH_PERF_CNT_EN
  logic [63:0] F_icount;
`endif

  int checks = 0;
  int errors = 0;
  longint unsigned exp_icount = 0;

  fetch_stage #(.RESET_PC(64'd0)) dut (
    .clk(clk), .rst(rst),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
    .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valA(M_valA),
    .W_icode(W_icode), .W_valM(W_valM),
    .ib0(ib[7:0]),   .ib1(ib[15:8]),  .ib2(ib[23:16]), .ib3(ib[31:24]),
    .ib4(ib[39:32]), .ib5(ib[47:40]), .ib6(ib[55:48]), .ib7(ib[63:56]),
    .ib8(ib[71:64]), .ib9(ib[79:72]),
    .imem_error(imem_error),
    .f_pc(f_pc), .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun),
    .D_rA(D_rA), .D_rB(D_rB), .D_valC(D_valC), .D_valP(D_valP)
`ifdef FETCH_PERF_CNT_EN
    , .F_icount(F_icount)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  m_icode;
    logic        m_cnd;
    logic [63:0] m_vala;
    logic [3:0]  w_icode;
    logic [63:0] w_valm;
    logic [79:0] ib;
    logic        ierr;
    logic [63:0] e_fpc;
    logic [2:0]  e_stat;
    logic [3:0]  e_icode, e_ifun, e_ra, e_rb;
    logic [63:0] e_valc, e_valp;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mkv(
    input logic [3:0] mi, input logic mc, input logic [63:0] ma,
    input logic [3:0] wi, input logic [63:0] wm, input logic [79:0] b,
    input logic er, input logic [63:0] fpc, input logic [2:0] st,
    input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
    input logic [3:0] rb, input logic [63:0] vc, input logic [63:0] vp);
    vec_t v;
    v.m_icode = mi; v.m_cnd = mc; v.m_vala = ma; v.w_icode = wi; v.w_valm = wm;
    v.ib = b; v.ierr = er; v.e_fpc = fpc; v.e_stat = st; v.e_icode = ic;
    v.e_ifun = fn; v.e_ra = ra; v.e_rb = rb; v.e_valc = vc; v.e_valp = vp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_d(input string tag, input logic [2:0] st, input logic [3:0] ic,
                       input logic [3:0] fn, input logic [3:0] ra, input logic [3:0] rb,
                       input logic [63:0] vc, input logic [63:0] vp);
    chk({tag, ".D_stat"},  {61'd0, D_stat},  {61'd0, st});
    chk({tag, ".D_icode"}, {60'd0, D_icode}, {60'd0, ic});
    chk({tag, ".D_ifun"},  {60'd0, D_ifun},  {60'd0, fn});
    chk({tag, ".D_rA"},    {60'd0, D_rA},    {60'd0, ra});
    chk({tag, ".D_rB"},    {60'd0, D_rB},    {60'd0, rb});
    chk({tag, ".D_valC"},  D_valC, vc);
    chk({tag, ".D_valP"},  D_valP, vp);
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst && !D_stall && !D_bubble) exp_icount++;
    #1;
  endtask

  task automatic chk_cnt(input string tag);
`ifdef FETCH_PERF_CNT_EN
    chk({tag, ".F_icount"}, F_icount, exp_icount);
`endif
  endtask

  initial begin
    // {M_icode,M_Cnd,M_valA,W_icode,W_valM,bytes,imem_err} -> {f_pc, D fields}
    vecs[0]  = mkv(0,0,0, 0,0, 80'h0A_F230, 0, 64'h0,  1, 3, 0, 4'hF, 2, 64'd10, 64'd10);
    vecs[1]  = mkv(0,0,0, 0,0, 80'h10,      0, 64'hA,  1, 1, 0, 4'hF, 4'hF, 0, 64'hB);
    vecs[2]  = mkv(0,0,0, 0,0, 80'h2360,    0, 64'hB,  1, 6, 0, 2, 3, 0, 64'hD);
    vecs[3]  = mkv(0,0,0, 0,0, 80'h0580,    0, 64'hD,  1, 8, 0, 4'hF, 4'hF, 64'h5, 64'h16);
    vecs[4]  = mkv(0,0,0, 0,0, 80'h2070,    0, 64'h5,  1, 7, 0, 4'hF, 4'hF, 64'h20, 64'hE);
    vecs[5]  = mkv(7,0,64'hE, 9,64'h40, 80'h10, 0, 64'hE, 1, 1, 0, 4'hF, 4'hF, 0, 64'hF);
    vecs[6]  = mkv(7,1,64'hE, 9,64'h40, 80'h90, 0, 64'h40, 1, 9, 0, 4'hF, 4'hF, 0, 64'h41);
    vecs[7]  = mkv(0,0,0, 0,0, 80'h0A_F230, 1, 64'h41, 3, 1, 0, 4'hF, 4'hF, 0, 64'h42);
    vecs[8]  = mkv(0,0,0, 0,0, 80'hD0,      0, 64'h42, 4, 4'hD, 0, 4'hF, 4'hF, 0, 64'h43);
    vecs[9]  = mkv(0,0,0, 0,0, 80'h00,      0, 64'h43, 2, 0, 0, 4'hF, 4'hF, 0, 64'h44);
    vecs[10] = mkv(0,0,0, 0,0, 80'h0807060504030201F330, 0, 64'h44, 1, 3, 0, 4'hF, 3,
                   64'h0807060504030201, 64'h4E);
    vecs[11] = mkv(0,0,0, 0,0, 80'h4521,    0, 64'h4E, 1, 2, 1, 4, 5, 0, 64'h50);
    vecs[12] = mkv(0,0,0, 9,64'hFFFF_FFFF_FFFF_FFFE, 80'hF030, 0, 64'hFFFF_FFFF_FFFF_FFFE,
                   1, 3, 0, 4'hF, 0, 0, 64'h8);
    vecs[13] = mkv(0,0,0, 0,0, 80'h01_0071, 0, 64'h8,  1, 7, 1, 4'hF, 4'hF, 64'h100, 64'h11);
    vecs[14] = mkv(0,0,0, 0,0, 80'h10_3540, 0, 64'h100, 1, 4, 0, 3, 5, 64'h10, 64'h10A);

    // Asynchronous reset: D shows bubble before any clock edge.
    #1 rst = 1'b1;
    #1;
    chk_d("reset", 1, 1, 0, 4'hF, 4'hF, 0, 0);
    chk("reset.f_pc", f_pc, 64'h0);
    chk_cnt("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      M_icode = vecs[i].m_icode; M_Cnd = vecs[i].m_cnd; M_valA = vecs[i].m_vala;
      W_icode = vecs[i].w_icode; W_valM = vecs[i].w_valm;
      ib = vecs[i].ib; imem_error = vecs[i].ierr;
      #1;
      chk($sformatf("vec%0d.f_pc", i), f_pc, vecs[i].e_fpc);
      step();
      chk_d($sformatf("vec%0d", i), vecs[i].e_stat, vecs[i].e_icode, vecs[i].e_ifun,
            vecs[i].e_ra, vecs[i].e_rb, vecs[i].e_valc, vecs[i].e_valp);
      @(negedge clk);
    end
    M_icode = 0; M_Cnd = 0; M_valA = 0; W_icode = 0; W_valM = 0; imem_error = 0;
    chk_cnt("after_table");

    // Stall and bubble together: D holds for two cycles while F advances.
    ib = 80'h10;
    D_stall = 1'b1; D_bubble = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk($sformatf("hold%0d.f_pc", k), f_pc, 64'h10A + 64'(k));
      step();
      chk_d($sformatf("hold%0d", k), 1, 4, 0, 3, 5, 64'h10, 64'h10A);
      @(negedge clk);
    end

    // Bubble alone with F_stall: D becomes bubble, predicted PC does not move.
    D_stall = 1'b0; F_stall = 1'b1;
    #1;
    chk("bubble.f_pc_pre", f_pc, 64'h10C);
    step();
    chk_d("bubble", 1, 1, 0, 4'hF, 4'hF, 0, 0);
    chk("fstall.f_pc", f_pc, 64'h10C);
    @(negedge clk);

    // Normal load, then reset asserted mid-cycle.
    F_stall = 1'b0; D_bubble = 1'b0; ib = 80'h0A_F230;
    step();
    chk_d("preload", 1, 3, 0, 4'hF, 2, 64'd10, 64'h116);
    chk_cnt("preload");
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    exp_icount = 0;
    chk_d("midrst", 1, 1, 0, 4'hF, 4'hF, 0, 0);
    chk("midrst.f_pc", f_pc, 64'h0);
    chk_cnt("midrst");
    @(negedge clk);
    rst = 1'b0; ib = 80'h10;
    #1;
    chk("postrst.f_pc", f_pc, 64'h0);
    step();
    chk_d("postrst", 1, 1, 0, 4'hF, 4'hF, 0, 64'h1);
    chk_cnt("postrst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
